// File: rtl/syn_hazard_controller_pkg.sv
// Shared definitions for the hazard controller: forwarding selects, FSM states
// and the hardwired-zero register number.
package syn_hazard_controller_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_DM = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN,
    ST_MDU_WAIT
  } hz_state_t;

  // The younger producer in EX always wins over the older one in DM.
  function automatic logic [1:0] fwd_sel(input logic c_ex, input logic c_dm);
    if (c_ex)
      return FWD_EX;
    else if (c_dm)
      return FWD_DM;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/syn_hazard_controller_stall_counter.sv
// Saturating up-counter with synchronous clear, used to count stall cycles
// for the performance display.
module syn_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/syn_hazard_controller.sv
// Pipeline hazard controller: qualifies detector collisions with a shadow of
// in-flight writers/loads and drives forwarding, stalls, flushes and MDU waits.
module syn_hazard_controller
  import syn_hazard_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ex_collision_a,
  input  logic             ex_collision_b,
  input  logic             dm_collision_a,
  input  logic             dm_collision_b,
  input  logic [4:0]       regfile_req_a,
  input  logic [4:0]       regfile_req_b,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mdu_start,
  input  logic             mdu_done,
  input  logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             req_w_gate,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_t state, state_next;

  logic ex_wr, ex_ld, dm_wr, dm_ld;
  logic c_ex_a, c_ex_b, c_dm_a, c_dm_b;
  logic load_use;

  // A bubbled instruction must not be seen as a writer or a load downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wr <= 1'b0;
      ex_ld <= 1'b0;
      dm_wr <= 1'b0;
      dm_ld <= 1'b0;
    end else if (en) begin
      ex_wr <= id_reg_write & ~bubble_ex;
      ex_ld <= id_mem_read & ~bubble_ex;
      dm_wr <= ex_wr;
      dm_ld <= ex_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  // Raw detector flags only count when the producer really writes and the
  // consumer really reads a register other than $0.
  assign c_ex_a = ex_collision_a & ex_wr & id_uses_a & (regfile_req_a != REG_ZERO);
  assign c_ex_b = ex_collision_b & ex_wr & id_uses_b & (regfile_req_b != REG_ZERO);
  assign c_dm_a = dm_collision_a & dm_wr & id_uses_a & (regfile_req_a != REG_ZERO);
  assign c_dm_b = dm_collision_b & dm_wr & id_uses_b & (regfile_req_b != REG_ZERO);

  assign fwd_a = fwd_sel(c_ex_a, c_dm_a);
  assign fwd_b = fwd_sel(c_ex_b, c_dm_b);

  assign load_use = (c_ex_a | c_ex_b) & ex_ld;

  always_comb begin
    state_next  = state;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;

    if (branch_taken) begin
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else if ((state == ST_MDU_WAIT) && !mdu_done) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else if (load_use) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end

    // A taken branch squashes any MDU op sitting in ID, so it never issues.
    case (state)
      ST_RUN:
        if (id_mdu_start && !stall_if_id && !branch_taken && en)
          state_next = ST_MDU_WAIT;
      ST_MDU_WAIT:
        if (mdu_done && en)
          state_next = ST_RUN;
      default:
        state_next = ST_RUN;
    endcase
  end

  assign req_w_gate = ~bubble_ex;

  syn_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .clr   (rst),
    .inc   (en & stall_if_id),
    .count (stall_cycles)
  );

  // dm_ld is carried for pipeline completeness; no current hazard needs it.
  logic unused_dm_ld;
  assign unused_dm_ld = dm_ld;

endmodule
